retire_trace_buffer: RTL
========================

RETIRE_TRACE_BUFFER -- requirements
Module: retire_trace_buffer

Interface
REQ-001 Parameters SHALL be:
- ADDRESS_WIDTH, 32, PC width.
- DATA_WIDTH, 32, result width.
- NUM_THREADS, 8, hardware thread count; power of 2, >=2.
- DEPTH, 16, FIFO entries; power of 2, >=2.
REQ-002 TW SHALL denote clog2(NUM_THREADS); CW SHALL denote clog2(DEPTH)+1.
REQ-003 Ports SHALL be:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- ret_valid  in  1  one instruction retired this cycle.
- ret_tid  in  TW  thread of the retired instruction.
- ret_pc  in  ADDRESS_WIDTH  PC of the retired instruction.
- ret_result  in  DATA_WIDTH  writeback value (the CPU "result").
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry.
- out_tid  out  TW  head thread ID.
- out_pc  out  ADDRESS_WIDTH  head PC.
- out_result  out  DATA_WIDTH  head result.
- count  out  CW  current occupancy.
- overflow  out  1  sticky; at least one retire was dropped.
- drop_count  out  16  dropped retires, saturating.
- halted  out  NUM_THREADS  per-thread sticky halt flag.
- all_halted  out  1  AND of all halted bits.

Function
REQ-004 The block SHALL capture each retire (ret_valid=1) as the tuple {tid, pc, result} into an in-order FIFO of DEPTH entries.
REQ-005 Push SHALL occur when ret_valid=1 and (count<DEPTH, or count==DEPTH and pop occurs in the same cycle).
REQ-006 Pop SHALL occur when out_valid=1 and out_ready=1; out_ready with out_valid=0 SHALL have no effect.
REQ-007 out_valid SHALL equal (count!=0). out_* SHALL present the head entry combinationally from storage (show-ahead). out_* values while out_valid=0 SHALL be don't-care.
REQ-008 An entry pushed at edge N SHALL be visible on out_* in cycle N+1 if the FIFO was empty. Latency: 1 cycle.
REQ-009 count SHALL update at each edge by +1 on push only, -1 on pop only, and 0 on both or neither.
REQ-010 Read and write pointers SHALL be CW-1 bits wide and wrap modulo DEPTH.
REQ-011 A retire that is not pushed SHALL set overflow=1 and increment drop_count; drop_count SHALL saturate at 16'hFFFF.
REQ-012 Per thread, the block SHALL hold last_pc[t] and seen[t]. On every retire of thread t, including dropped retires:
- If seen[t]=1 and ret_pc==last_pc[t], halted[t] SHALL be set.
- last_pc[t] SHALL be loaded with ret_pc and seen[t] set to 1.
REQ-013 halted bits SHALL be sticky until reset. A later different PC on a halted thread SHALL NOT clear its bit.
REQ-014 halted[t] SHALL rise at the edge that captures the repeated retire and be visible in the following cycle. all_halted SHALL be combinational from halted.
REQ-015 Halt detection SHALL be independent of FIFO state and of out_ready.

Reset
REQ-016 While rst=1 at a clock edge, the block SHALL set count=0, both pointers=0, overflow=0, drop_count=0, halted=0, and seen=0.
REQ-017 Reset SHALL override any simultaneous push or pop. Retires presented during reset SHALL be discarded and SHALL NOT be counted as drops.
REQ-018 FIFO storage and last_pc SHALL NOT require reset.
REQ-019 Reset asserted mid-operation SHALL empty the FIFO in one edge; out_valid SHALL be 0 in the following cycle.

Structure
REQ-020 The shared package mt_cpu_pkg SHALL hold the default ADDRESS_WIDTH, DATA_WIDTH, and NUM_THREADS constants and the trace-entry typedef {tid, pc, result}.
REQ-021 FIFO storage and pointers SHALL be one sub-module, trace_fifo, parameterised by entry width and DEPTH. Halt tracking and drop counting SHALL reside in retire_trace_buffer.
REQ-022 Estimated RTL size SHALL be 150-300 lines in total.

Verification
REQ-023 Basic: reset, then a retire {tid=3, pc=0x40, result=0xDEADBEEF} -> next cycle out_valid=1, out_tid=3, out_pc=0x40, out_result=0xDEADBEEF, count=1; pop with out_ready=1 -> count=0.
REQ-024 Fill and overflow: out_ready=0, 18 consecutive retires -> count=16, overflow=1, drop_count=2; the first 16 entries drain in order.
REQ-025 Full plus simultaneous pop/push: count=16, out_ready=1, ret_valid=1 -> count stays 16, no drop, and the new entry appears last.
REQ-026 Halt: thread 5 retires pc 0x100 then 0x100 -> halted=8'h20 next cycle. Thread 2 retires 0x10 then 0x14 -> no halt. All 8 threads repeating their PCs -> all_halted=1.
REQ-027 Reset mid-stream: count=7, halted=8'h0F, rst pulsed one cycle -> count=0, out_valid=0, halted=0, drop_count=0. A first retire per thread after reset SHALL NOT set halt.
REQ-028 Randomized out_ready with random retires for 10000 cycles -> popped sequence equals a scoreboard of accepted pushes, and drop_count equals the scoreboard drop count.

Source files
------------

// File: rtl/mt_cpu_pkg.sv
// Shared CPU-wide defaults and the retire trace entry layout.
package mt_cpu_pkg;
  localparam int unsigned DEF_ADDRESS_WIDTH = 32;
  localparam int unsigned DEF_DATA_WIDTH    = 32;
  localparam int unsigned DEF_NUM_THREADS   = 8;
  localparam int unsigned DEF_TID_WIDTH     = $clog2(DEF_NUM_THREADS);

  typedef struct packed {
    logic [DEF_TID_WIDTH-1:0]     tid;
    logic [DEF_ADDRESS_WIDTH-1:0] pc;
    logic [DEF_DATA_WIDTH-1:0]    result;
  } trace_entry_t;
endpackage

// File: rtl/retire_trace_buffer_if.sv
// Retire input and show-ahead trace output bundle of the retire trace buffer.
interface retire_trace_buffer_if
  import mt_cpu_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned NUM_THREADS   = DEF_NUM_THREADS
);
  localparam int unsigned TW = $clog2(NUM_THREADS);

  logic                     ret_valid;
  logic [TW-1:0]            ret_tid;
  logic [ADDRESS_WIDTH-1:0] ret_pc;
  logic [DATA_WIDTH-1:0]    ret_result;
  logic                     out_valid;
  logic                     out_ready;
  logic [TW-1:0]            out_tid;
  logic [ADDRESS_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0]    out_result;

  modport master (
    output ret_valid, ret_tid, ret_pc, ret_result, out_ready,
    input  out_valid, out_tid, out_pc, out_result
  );

  modport slave (
    input  ret_valid, ret_tid, ret_pc, ret_result, out_ready,
    output out_valid, out_tid, out_pc, out_result
  );
endinterface

// File: rtl/retire_trace_buffer_fifo.sv
// Show-ahead FIFO; a full FIFO still accepts a write when it is popped in the same cycle.
module trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_req,
  input  logic                     i_rd_req,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_push,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_rd_req && (r_count != '0);
  assign w_push = i_wr_req && ((r_count != FULL) || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = r_mem[r_rptr];
  assign o_push  = w_push;
  assign o_count = r_count;
endmodule

// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: in-order trace FIFO with drop accounting and per-thread
// self-loop (halt) detection on repeated retire PCs.
module retire_trace_buffer
  import mt_cpu_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned NUM_THREADS   = DEF_NUM_THREADS,
  parameter int unsigned DEPTH         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  retire_trace_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  output logic [NUM_THREADS-1:0]   halted,
  output logic                     all_halted
);
  localparam int unsigned TW = $clog2(NUM_THREADS);
  localparam int unsigned EW = TW + ADDRESS_WIDTH + DATA_WIDTH;

  logic [EW-1:0]            w_wdata;
  logic [EW-1:0]            w_rdata;
  logic                     w_push;
  logic [ADDRESS_WIDTH-1:0] r_last_pc [NUM_THREADS];
  logic [NUM_THREADS-1:0]   r_seen;
  logic [NUM_THREADS-1:0]   r_halted;
  logic                     r_overflow;
  logic [15:0]              r_drop_count;

  assign w_wdata = {bus.ret_tid, bus.ret_pc, bus.ret_result};

  trace_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_wr_req (bus.ret_valid),
    .i_rd_req (bus.out_ready),
    .i_data   (w_wdata),
    .o_data   (w_rdata),
    .o_push   (w_push),
    .o_count  (count)
  );

  assign bus.out_valid = (count != '0);
  assign {bus.out_tid, bus.out_pc, bus.out_result} = w_rdata;

  // Halt tracking sees every retire, dropped or not, independent of the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seen       <= '0;
      r_halted     <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (bus.ret_valid) begin
      if (r_seen[bus.ret_tid] && (r_last_pc[bus.ret_tid] == bus.ret_pc))
        r_halted[bus.ret_tid] <= 1'b1;
      r_seen[bus.ret_tid] <= 1'b1;
      if (!w_push) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && bus.ret_valid) r_last_pc[bus.ret_tid] <= bus.ret_pc;
  end

  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
  assign halted     = r_halted;
  assign all_halted = &r_halted;
endmodule
